// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF synchroniser, optional parity, 1/2 stop bits, error pulses and a receive FIFO.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote of the last three clocks.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int NUM_BITS   = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_data,
  output logic [NUM_BITS-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_parity_err,
  output logic                o_frame_err,
  output logic                o_overrun
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(NUM_BITS);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                perr_q, perr_d;
  logic                stop_q, stop_d;
  logic                pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic                push_req;
  logic                rx;
  logic [CW-1:0]       target;
  logic                at_sample;
  logic                bit_val;

  assign rx = sync_q[1];
  // START decides at the half-bit point; every other state at the end of the bit.
  assign target    = (state_q == S_START) ? CNT_HALF : CNT_LAST;
  assign at_sample = (cnt_q == target);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (cnt_q == target - CW'(2)) vote_d[0] = rx;
    if (cnt_q == target - CW'(1)) vote_d[1] = rx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vote_q <= 2'b11;
    else          vote_q <= vote_d;
  end

  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx) | (vote_q[1] & rx);
`else
  assign bit_val = rx;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      stop_q  <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_data};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      stop_q  <= stop_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    stop_d   = stop_q;
    push_req = 1'b0;
    pe_d     = 1'b0;
    fe_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = S_START;
      end
      S_START: begin
        if (at_sample) begin
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          stop_d  = 1'b0;
          state_d = bit_val ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (at_sample) begin
          cnt_d          = '0;
          shift_d[idx_q] = bit_val;
          if (idx_q == IW'(NUM_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                            idx_d   = idx_q + IW'(1);
        end
      end
      S_PARITY: begin
        if (at_sample) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 1) ? ~(^shift_q ^ bit_val) : (^shift_q ^ bit_val);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (at_sample) begin
          cnt_d = '0;
          if (!bit_val) begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end else if (STOP_BITS == 1 || stop_q) begin
            // Leave half a bit early so a back-to-back start edge is not missed.
            state_d = S_IDLE;
            if (perr_q) pe_d     = 1'b1;
            else        push_req = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [NUM_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         fcnt_q;
  logic                full, pop, push;

  assign full = (fcnt_q == (AW + 1)'(FIFO_DEPTH));
  assign pop  = o_valid && i_ready;
  assign push = push_req && (!full || pop);
  assign ov_d = push_req && full && !pop;

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= shift_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)      fcnt_q <= fcnt_q + (AW + 1)'(1);
      else if (pop && !push) fcnt_q <= fcnt_q - (AW + 1)'(1);
    end
  end

  assign o_valid      = (fcnt_q != '0);
  assign o_data       = o_valid ? mem_q[rd_q] : '0;
  assign o_busy       = (state_q != S_IDLE);
  assign o_parity_err = pe_q;
  assign o_frame_err  = fe_q;
  assign o_overrun    = ov_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, 12 clocks per bit,
// checked against a frame-level scoreboard every cycle plus hand-computed literals.
module tb_uart_rx_fifo;
  localparam int CPB = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line0 = 1'b1, line1 = 1'b1;
  logic rdy [2];
  logic [7:0] dat0, dat1;
  logic vld0, vld1, busy0, busy1, pe0, pe1, fe0, fe1, ov0, ov1;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(12000000), .BAUD(1000000), .NUM_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(line0), .o_data(dat0), .o_valid(vld0),
    .i_ready(rdy[0]), .o_busy(busy0), .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0));

  uart_rx_fifo #(.CLK_FREQ(12000000), .BAUD(1000000), .NUM_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(line1), .o_data(dat1), .o_valid(vld1),
    .i_ready(rdy[1]), .o_busy(busy1), .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mq0[$], mq1[$];
  int n_chk = 0, n_fail = 0;
  int exp_pe [2], exp_fe [2], exp_ov [2];
  int obs_pe [2], obs_fe [2], obs_ov [2], pops [2];
  int rise_cyc [2], start_cyc [2];
  logic prev_v [2], prev_r [2], prev_p [2];
  logic [7:0] prev_d [2], last_pop [2];

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic cyc_check(input int k, input logic [7:0] d, input logic v, input logic r,
                           input logic b, input logic p, input logic f, input logic o);
    logic [7:0] front;
    if (!rst_n) begin
      chk("reset_outputs", int'({d, v, b, p, f, o}), 0);
      prev_v[k] = 1'b0; prev_r[k] = 1'b0; prev_p[k] = 1'b0; prev_d[k] = 8'h00;
      return;
    end
    chk("pulse_exclusive", int'(p) + int'(f) + int'(o) <= 1 ? 1 : 0, 1);
    if (p || f || o) chk("pulse_one_cycle", int'(prev_p[k]), 0);
    if (p) obs_pe[k]++;
    if (f) obs_fe[k]++;
    if (o) obs_ov[k]++;
    if (!v) chk("empty_data_zero", int'(d), 0);
    if (v && prev_v[k] && !prev_r[k]) chk("data_held", int'(d), int'(prev_d[k]));
    if (v && !prev_v[k]) rise_cyc[k] = cyc;
    if (v && r) begin
      n_chk++;
      if (qsize(k) == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: dut%0d delivered 0x%02h, required no data", k, d);
      end else begin
        front = (k == 0) ? mq0.pop_front() : mq1.pop_front();
        if (d != front) begin
          n_fail++;
          $display("FAIL pop_data: dut%0d got 0x%02h, required 0x%02h", k, d, front);
        end
      end
      pops[k]++;
      last_pop[k] = d;
      $display("pop dut%0d data=0x%02h cycle=%0d", k, d, cyc);
    end
    prev_v[k] = v; prev_r[k] = r; prev_d[k] = d; prev_p[k] = p | f | o;
  endtask

  always @(negedge clk) begin
    cyc_check(0, dat0, vld0, rdy[0], busy0, pe0, fe0, ov0);
    cyc_check(1, dat1, vld1, rdy[1], busy1, pe1, fe1, ov1);
  end

  task automatic drive_bit(input int k, input logic v);
    if (k == 0) line0 = v; else line1 = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pbit < 0 sends no parity bit; otherwise it is the parity bit placed on the wire.
  task automatic send(input int k, input logic [7:0] d, input int pbit, input logic stopv);
    if (!stopv) exp_fe[k]++;
    else if (pbit >= 0 && pbit != int'(^d)) exp_pe[k]++;
    else if (qsize(k) >= 4) exp_ov[k]++;
    else if (k == 0) mq0.push_back(d);
    else mq1.push_back(d);
    start_cyc[k] = cyc;
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
    if (pbit >= 0) drive_bit(k, pbit[0]);
    drive_bit(k, stopv);
  endtask

  task automatic check_errs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_parity_cnt"}, obs_pe[k], exp_pe[k]);
      chk({tag, "_frame_cnt"}, obs_fe[k], exp_fe[k]);
      chk({tag, "_overrun_cnt"}, obs_ov[k], exp_ov[k]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    for (int k = 0; k < 2; k++) begin
      exp_pe[k] = 0; exp_fe[k] = 0; exp_ov[k] = 0; obs_pe[k] = 0; obs_fe[k] = 0; obs_ov[k] = 0;
      pops[k] = 0; rise_cyc[k] = 0; start_cyc[k] = 0; last_pop[k] = 8'h00;
      prev_v[k] = 1'b0; prev_r[k] = 1'b0; prev_p[k] = 1'b0; prev_d[k] = 8'h00;
      rdy[k] = 1'b1;
    end
    rst_n = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(4);

    // 1: 8N1 0xA5, o_valid 117 clocks after the start bit is driven
    send(0, 8'hA5, -1, 1'b1);
    idle(2);
    chk("t1_valid_latency", rise_cyc[0] - start_cyc[0], 117);
    chk("t1_data", int'(last_pop[0]), 8'hA5);
    chk("t1_busy_low", int'(busy0), 0);
    chk("t1_pops", pops[0], 1);

    // 2: 3-clock glitch
    idle(CPB);
    line0 = 1'b0;
    idle(3);
    line0 = 1'b1;
    idle(8);
    chk("t2_busy_low", int'(busy0), 0);
    chk("t2_no_valid", int'(vld0), 0);
    check_errs("t2");

    // 3: even parity, bad then good parity bit
    send(1, 8'h03, 1, 1'b1);
    idle(2 * CPB);
    chk("t3_parity_err", obs_pe[1], 1);
    chk("t3_no_data", pops[1], 0);
    send(1, 8'h03, 0, 1'b1);
    idle(2);
    chk("t3_data", int'(last_pop[1]), 8'h03);
    check_errs("t3");

    // 4: stop bit low, line held low, then a clean frame
    idle(CPB);
    send(0, 8'h55, -1, 1'b0);
    idle(30);
    line0 = 1'b1;
    idle(2 * CPB);
    chk("t4_frame_err", obs_fe[0], 1);
    chk("t4_no_data", pops[0], 1);
    send(0, 8'h12, -1, 1'b1);
    idle(2);
    chk("t4_next_data", int'(last_pop[0]), 8'h12);
    check_errs("t4");

    // 5: fill the FIFO with i_ready low, fifth frame overruns, then drain
    idle(CPB);
    rdy[0] = 1'b0;
    for (int i = 1; i <= 5; i++) send(0, 8'(i), -1, 1'b1);
    idle(2);
    chk("t5_overrun", obs_ov[0], 1);
    chk("t5_head_held", int'(dat0), 8'h01);
    p0 = pops[0];
    rdy[0] = 1'b1;
    for (int t = 0; t < 20 && mq0.size() != 0; t++) idle(1);
    idle(1);
    chk("t5_drained_model", mq0.size(), 0);
    chk("t5_drain_count", pops[0] - p0, 4);
    chk("t5_last", int'(last_pop[0]), 8'h04);
    chk("t5_valid_low", int'(vld0), 0);
    check_errs("t5");

    // 6: reset in the middle of 0x3C with a word already queued
    idle(CPB);
    rdy[0] = 1'b0;
    send(0, 8'h77, -1, 1'b1);
    idle(2);
    chk("t6_fifo_holds", int'(vld0), 1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 8'h3C >> i & 8'h01 ? 1'b1 : 1'b0);
    rst_n = 1'b0;
    mq0.delete();
    mq1.delete();
    line0 = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(2);
    chk("t6_valid_after_reset", int'(vld0), 0);
    chk("t6_busy_after_reset", int'(busy0), 0);
    rdy[0] = 1'b1;
    p0 = pops[0];
    idle(2 * CPB);
    send(0, 8'hC3, -1, 1'b1);
    idle(2 * CPB);
    chk("t6_single_pop", pops[0] - p0, 1);
    chk("t6_data", int'(last_pop[0]), 8'hC3);
    check_errs("t6");
    chk("final_model_empty", mq0.size() + mq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
